// File: rtl/stream_mux_2to1.sv
// rtl/stream_mux_2to1.sv - round-robin 2:1 stream merge with registered, source-tagged output
// Optional per-channel accepted-word counters: define MUX_CNT_EN.
module stream_mux_2to1 #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] B_in,
  input  logic             B_valid,
  output logic             B_ready,
  input  logic [WIDTH-1:0] C_in,
  input  logic             C_valid,
  output logic             C_ready,
  output logic [WIDTH-1:0] A_out,
  output logic             Select_out,
  output logic             A_valid,
  input  logic             A_ready
`ifdef MUX_CNT_EN
  ,
  output logic [CNT_W-1:0] B_cnt,
  output logic [CNT_W-1:0] C_cnt
`endif
);

  localparam logic SEL_B = 1'b0;
  localparam logic SEL_C = 1'b1;

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("stream_mux_2to1: WIDTH and CNT_W must be at least 1");
  end

  logic [WIDTH-1:0] a_out_q, a_out_d;
  logic             sel_q, sel_d;
  logic             a_valid_q, a_valid_d;
  logic             last_sel_q, last_sel_d;

  logic             grant;
  logic             load;
  logic             b_ready;
  logic             c_ready;

  // On a tie, the channel that did not win last time gets the slot.
  always_comb begin
    grant = SEL_B;
    if (B_valid && C_valid) begin
      grant = ~last_sel_q;
    end else if (C_valid) begin
      grant = SEL_C;
    end
  end

  assign load    = ~rst & (B_valid | C_valid) & (~a_valid_q | A_ready);
  assign b_ready = load & (grant == SEL_B);
  assign c_ready = load & (grant == SEL_C);

  always_comb begin
    a_out_d    = a_out_q;
    sel_d      = sel_q;
    a_valid_d  = a_valid_q;
    last_sel_d = last_sel_q;
    if (load) begin
      a_out_d    = (grant == SEL_C) ? C_in : B_in;
      sel_d      = grant;
      a_valid_d  = 1'b1;
      last_sel_d = grant;
    end else if (a_valid_q && A_ready) begin
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out_q    <= '0;
      sel_q      <= SEL_B;
      a_valid_q  <= 1'b0;
      last_sel_q <= SEL_C;
    end else begin
      a_out_q    <= a_out_d;
      sel_q      <= sel_d;
      a_valid_q  <= a_valid_d;
      last_sel_q <= last_sel_d;
    end
  end

  assign B_ready    = b_ready;
  assign C_ready    = c_ready;
  assign A_out      = a_out_q;
  assign Select_out = sel_q;
  assign A_valid    = a_valid_q;

`ifdef MUX_CNT_EN
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic [CNT_W-1:0] c_cnt_q, c_cnt_d;

  // Saturating counts of accepted words; they stick at all-ones.
  always_comb begin
    b_cnt_d = b_cnt_q;
    c_cnt_d = c_cnt_q;
    if (b_ready && B_valid && (b_cnt_q != {CNT_W{1'b1}})) begin
      b_cnt_d = b_cnt_q + CNT_W'(1);
    end
    if (c_ready && C_valid && (c_cnt_q != {CNT_W{1'b1}})) begin
      c_cnt_d = c_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      b_cnt_q <= b_cnt_d;
      c_cnt_q <= c_cnt_d;
    end
  end

  assign B_cnt = b_cnt_q;
  assign C_cnt = c_cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_2to1.sv
// tb/tb_stream_mux_2to1.sv - directed scoreboard bench for stream_mux_2to1
// Counter checks are compiled in when MUX_CNT_EN is defined.
module tb_stream_mux_2to1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] B_in, C_in;
  logic       B_valid, C_valid, A_ready;
  logic       B_ready, C_ready;
  logic [1:0] A_out;
  logic       Select_out, A_valid;
`ifdef MUX_CNT_EN
  logic [1:0] B_cnt, C_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] sb[$];
  logic       m_valid;
  logic       m_last;
  logic       m_load;
  logic       m_grant;
  int         m_bcnt;
  int         m_ccnt;

  stream_mux_2to1 #(.WIDTH(2), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .B_in       (B_in),
    .B_valid    (B_valid),
    .B_ready    (B_ready),
    .C_in       (C_in),
    .C_valid    (C_valid),
    .C_ready    (C_ready),
    .A_out      (A_out),
    .Select_out (Select_out),
    .A_valid    (A_valid),
    .A_ready    (A_ready)
`ifdef MUX_CNT_EN
    ,
    .B_cnt      (B_cnt),
    .C_cnt      (C_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check against the model mid-cycle, then advance the model.
  task automatic step(input logic r, input logic bv, input logic [1:0] bd,
                      input logic cv, input logic [1:0] cd, input logic ar);
    rst = r; B_valid = bv; B_in = bd; C_valid = cv; C_in = cd; A_ready = ar;
    @(negedge clk);
    m_grant = (bv && cv) ? ~m_last : (cv ? 1'b1 : 1'b0);
    m_load  = !r && (bv || cv) && (!m_valid || ar);
    chk("a_valid", 32'(A_valid), 32'(m_valid));
    if (m_valid && sb.size() > 0) begin
      chk("a_out", 32'(A_out), 32'(sb[0][1:0]));
      chk("select_out", 32'(Select_out), 32'(sb[0][2]));
    end
    chk("b_ready", 32'(B_ready), 32'(m_load && !m_grant));
    chk("c_ready", 32'(C_ready), 32'(m_load && m_grant));
`ifdef MUX_CNT_EN
    chk("b_cnt", 32'(B_cnt), 32'(m_bcnt));
    chk("c_cnt", 32'(C_cnt), 32'(m_ccnt));
`endif
    @(posedge clk);
    if (r) begin
      sb.delete();
      m_valid = 1'b0;
      m_last  = 1'b1;
      m_bcnt  = 0;
      m_ccnt  = 0;
    end else if (m_load) begin
      if (m_valid) void'(sb.pop_front());
      sb.push_back({m_grant, m_grant ? cd : bd});
      m_valid = 1'b1;
      m_last  = m_grant;
      if (m_grant) m_ccnt = (m_ccnt < 3) ? m_ccnt + 1 : 3;
      else         m_bcnt = (m_bcnt < 3) ? m_bcnt + 1 : 3;
    end else if (m_valid && ar) begin
      void'(sb.pop_front());
      m_valid = 1'b0;
    end
    #1;
  endtask

  logic [1:0] tie_exp [4];

  initial begin
    tie_exp[0] = 2'b10; tie_exp[1] = 2'b11; tie_exp[2] = 2'b10; tie_exp[3] = 2'b11;
    m_valid = 1'b0; m_last = 1'b1; m_bcnt = 0; m_ccnt = 0;
    rst = 1'b1; B_valid = 1'b0; C_valid = 1'b0; B_in = '0; C_in = '0; A_ready = 1'b1;

    // Reset held two cycles with both channels requesting
    step(1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    step(1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    chk("rst_a_out", 32'(A_out), 32'h0);
    chk("rst_select", 32'(Select_out), 32'h0);
    chk("rst_a_valid", 32'(A_valid), 32'h0);

    // B only, one word
    step(1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1);
    chk("b_only_a_out", 32'(A_out), 32'h1);
    chk("b_only_sel", 32'(Select_out), 32'h0);
    chk("b_only_valid", 32'(A_valid), 32'h1);
    step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

    // Ties alternate, starting with B after reset
    step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'b10, 1'b1, 2'b11, 1'b1);
      chk("tie_a_out", 32'(A_out), 32'(tie_exp[i]));
      chk("tie_sel", 32'(Select_out), 32'(i % 2));
    end

    // Stall with C waiting: output held, C not accepted
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0);
      chk("stall_a_out", 32'(A_out), 32'h3);
      chk("stall_valid", 32'(A_valid), 32'h1);
    end
    step(1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b1);
    chk("unstall_a_out", 32'(A_out), 32'h1);
    chk("unstall_sel", 32'(Select_out), 32'h1);

    // Reset while full, then B wins the first tie
    step(1'b1, 1'b1, 2'b00, 1'b1, 2'b11, 1'b0);
    chk("midrst_valid", 32'(A_valid), 32'h0);
    step(1'b0, 1'b1, 2'b00, 1'b1, 2'b11, 1'b1);
    chk("midrst_sel", 32'(Select_out), 32'h0);
    chk("midrst_a_out", 32'(A_out), 32'h0);
    step(1'b0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1);
    chk("midrst_c_next", 32'(Select_out), 32'h1);

    // Mixed random traffic and backpressure against the model
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)),
           2'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

`ifdef MUX_CNT_EN
    // Counter saturation at 2^CNT_W-1
    step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'(i), 1'b0, 2'b00, 1'b1);
    chk("b_cnt_sat", 32'(B_cnt), 32'h3);
    chk("c_cnt_zero", 32'(C_cnt), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
